// File: rtl/keccak_pkg.sv
// Shared types and lane geometry for the keccak byte packer.
package keccak_pkg;

    localparam int unsigned LANE_W   = 8;
    localparam int unsigned LANE_MSB = 31;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFill,
        StSend,
        StTail,
        StWait,
        StDone
    } state_e;

    // Lane 0 is the most significant byte of the word.
    function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
        return 5'(LANE_MSB + 1 - LANE_W * (32'(lane) + 1));
    endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs a valid/ready byte stream into 32-bit words for the keccak core, clearing the core
// before every message and appending the empty final word when the length is a multiple of 4.
module keccak_byte_packer
    import keccak_pkg::*;
#(
    parameter logic [7:0]  PAD_BYTE   = 8'h00,
    parameter int unsigned CLR_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        core_reset,
    output logic [31:0] core_in,
    output logic        core_in_ready,
    output logic        core_is_last,
    output logic [1:0]  core_byte_num,
    input  logic        core_buffer_full,
    input  logic        core_out_ready,
    output logic        busy,
    output logic        msg_done
);

    localparam int unsigned     ClrW    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);
    localparam logic [31:0]     PadWord = {4{PAD_BYTE}};

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]     word_q, word_d;
    logic            last_q, last_d;
    logic [1:0]      bn_q, bn_d;
    logic            tail_q, tail_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            clr_cnt_q <= '0;
            word_q    <= PadWord;
            last_q    <= 1'b0;
            bn_q      <= '0;
            tail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_cnt_q <= clr_cnt_d;
            word_q    <= word_d;
            last_q    <= last_d;
            bn_q      <= bn_d;
            tail_q    <= tail_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        clr_cnt_d     = clr_cnt_q;
        word_d        = word_q;
        last_d        = last_q;
        bn_d          = bn_q;
        tail_d        = tail_q;
        s_ready       = 1'b0;
        core_reset    = 1'b0;
        core_in       = '0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = '0;
        msg_done      = 1'b0;
        busy          = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                clr_cnt_d = '0;
                if (s_valid) state_d = StClr;
            end
            StClr: begin
                core_reset = 1'b1;
                cnt_d      = '0;
                if (clr_cnt_q == ClrLast) begin
                    clr_cnt_d = '0;
                    state_d   = StFill;
                end else begin
                    clr_cnt_d = clr_cnt_q + ClrW'(1);
                end
            end
            StFill: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    word_d[lane_lsb(cnt_q) +: LANE_W] = s_data;
                    cnt_d = s_last ? 2'd0 : cnt_q + 2'd1;
                    // A final byte that completes a word defers is_last to the empty tail word.
                    if (s_last || cnt_q == 2'd3) begin
                        state_d = StSend;
                        last_d  = s_last && (cnt_q != 2'd3);
                        tail_d  = s_last && (cnt_q == 2'd3);
                        bn_d    = (s_last && cnt_q != 2'd3) ? cnt_q + 2'd1 : 2'd0;
                    end
                end
            end
            StSend: begin
                core_in_ready = 1'b1;
                core_in       = word_q;
                core_is_last  = last_q;
                core_byte_num = bn_q;
                if (!core_buffer_full) begin
                    word_d = PadWord;
                    last_d = 1'b0;
                    bn_d   = '0;
                    if (tail_q)      state_d = StTail;
                    else if (last_q) state_d = StWait;
                    else             state_d = StFill;
                end
            end
            StTail: begin
                core_in_ready = 1'b1;
                core_is_last  = 1'b1;
                if (!core_buffer_full) begin
                    tail_d  = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (core_out_ready) state_d = StDone;
            end
            StDone: begin
                msg_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Self-checking bench for keccak_byte_packer: directed vectors plus randomized messages
// checked against a word-level reference model.
module tb_keccak_byte_packer;

    localparam int unsigned CLR = 3;
    localparam logic [7:0]  PAD = 8'h00;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } word_t;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        core_reset;
    logic [31:0] core_in;
    logic        core_in_ready;
    logic        core_is_last;
    logic [1:0]  core_byte_num;
    logic        core_buffer_full;
    logic        core_out_ready;
    logic        busy;
    logic        msg_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg_q[$];
    word_t      exp_q[$];
    word_t      obs_q[$];

    int cyc            = 0;
    int md_cnt         = 0;
    int md_cyc         = -1;
    int or_cyc         = -1;
    int clr_hi         = 0;
    int clr_last_cyc   = -1;
    int first_xfer_cyc = -1;
    int or_cnt         = 0;
    int or_delay       = 7;
    bit bp_rand        = 1'b0;
    bit gap_en         = 1'b0;

    keccak_byte_packer #(
        .PAD_BYTE   (PAD),
        .CLR_CYCLES (CLR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .core_reset       (core_reset),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out_ready   (core_out_ready),
        .busy             (busy),
        .msg_done         (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observer: records every word transfer and the core-side handshakes.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (core_in_ready === 1'b1 && core_buffer_full === 1'b0) begin
            if (obs_q.size() == 0) first_xfer_cyc = cyc;
            obs_q.push_back({core_in, core_is_last, core_byte_num});
            if (core_is_last === 1'b1) or_cnt = or_delay;
        end
        if (core_reset === 1'b1) begin
            clr_hi++;
            clr_last_cyc = cyc;
        end
        if (core_out_ready === 1'b1) or_cyc = cyc;
        if (msg_done === 1'b1) begin
            md_cnt++;
            md_cyc = cyc;
        end
    end

    // Core model: optional random stall, digest ready a set delay after the last word.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_rand) core_buffer_full = ($urandom_range(0, 2) == 0);
        if (or_cnt > 0) begin
            or_cnt--;
            core_out_ready = (or_cnt == 0);
        end else begin
            core_out_ready = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500000");
        $fatal(1);
    end

    function automatic void load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endfunction

    // Reference model: chop the message into 4-byte words, pad the short final word,
    // append an empty last word when the length divides by 4.
    function automatic void build_model();
        int          len;
        int          nb;
        logic [31:0] w;
        exp_q.delete();
        len = msg_q.size();
        for (int k = 0; k < len; k += 4) begin
            nb = (len - k < 4) ? len - k : 4;
            w  = {4{PAD}};
            for (int j = 0; j < nb; j++) w[31 - 8 * j -: 8] = msg_q[k + j];
            exp_q.push_back({w, (nb < 4), (nb < 4) ? 2'(nb) : 2'd0});
        end
        if (len % 4 == 0) exp_q.push_back({32'h0, 1'b1, 2'd0});
    endfunction

    task automatic send_bytes(input bit with_last, output bit ok);
        bit acc;
        int n;
        ok = 1'b1;
        for (int i = 0; i < msg_q.size(); i++) begin
            if (gap_en && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b1;
            s_data  = msg_q[i];
            s_last  = with_last && (i == msg_q.size() - 1);
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 300) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) begin
                ok = 1'b0;
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int prev, output bit ok);
        int n = 0;
        while (md_cnt == prev && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = (md_cnt != prev);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({s_ready, core_reset, core_in_ready, core_is_last, busy, msg_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {s_ready, core_reset, core_in_ready, core_is_last, busy, msg_done});
        end
        checks++;
        if (core_in !== 32'h0 || core_byte_num !== 2'd0) begin
            errors++;
            $display("FAIL reset_word: got %h/%0d want 00000000/0", core_in, core_byte_num);
        end
        s_valid = 1'b1;
        s_data  = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, core_reset, busy} !== 3'b0) begin
            errors++;
            $display("FAIL reset_held: got %b want 000", {s_ready, core_reset, busy});
        end
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        string       vec[3];
        logic [31:0] tail_w[3];
        logic [31:0] got;
        bit          ok1, ok2;
        int          prev;
        vec[0] = "Hello, world";
        vec[1] = "Hello, world!";
        vec[2] = "1234567890";
        tail_w[0] = 32'h00000000;
        tail_w[1] = 32'h21000000;
        tail_w[2] = 32'h39300000;
        for (int v = 0; v < 3; v++) begin
            load_str(vec[v]);
            build_model();
            obs_q.delete();
            prev = md_cnt;
            send_bytes(1'b1, ok1);
            wait_done(prev, ok2);
            checks++;
            if (!(ok1 && ok2)) begin
                errors++;
                $display("FAIL vec%0d_handshake: got timeout want completion", v);
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL vec%0d_count: got %0d words want %0d", v, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL vec%0d_word%0d: got %h/%b/%0d want %h/%b/%0d", v, i, obs_q[i].w,
                             obs_q[i].last, obs_q[i].bn, exp_q[i].w, exp_q[i].last, exp_q[i].bn);
                end
            end
            got = (obs_q.size() > 0) ? obs_q[$].w : 32'hxxxxxxxx;
            checks++;
            if (got !== tail_w[v]) begin
                errors++;
                $display("FAIL vec%0d_final: got %h want %h", v, got, tail_w[v]);
            end
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[0].w !== 32'h31323334) begin
            errors++;
            $display("FAIL vec2_first: got %0d words want first 31323334", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        string names[2];
        bit    ok1, ok2;
        int    prev;
        int    start_md;
        names[0] = "abcde";
        names[1] = "fghijklm";
        or_delay = 7;
        start_md = md_cnt;
        for (int m = 0; m < 2; m++) begin
            load_str(names[m]);
            build_model();
            obs_q.delete();
            clr_hi         = 0;
            clr_last_cyc   = -1;
            first_xfer_cyc = -1;
            prev = md_cnt;
            send_bytes(1'b1, ok1);
            wait_done(prev, ok2);
            checks++;
            if (!(ok1 && ok2)) begin
                errors++;
                $display("FAIL b2b%0d_handshake: got timeout want completion", m);
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL b2b%0d_count: got %0d words want %0d", m, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b%0d_word%0d: got %h/%b/%0d want %h/%b/%0d", m, i, obs_q[i].w,
                             obs_q[i].last, obs_q[i].bn, exp_q[i].w, exp_q[i].last, exp_q[i].bn);
                end
            end
            checks++;
            if (clr_hi != CLR) begin
                errors++;
                $display("FAIL b2b%0d_clr_len: got %0d cycles want %0d", m, clr_hi, CLR);
            end
            checks++;
            if (!(clr_last_cyc >= 0 && clr_last_cyc < first_xfer_cyc)) begin
                errors++;
                $display("FAIL b2b%0d_clr_order: got clr@%0d word@%0d want clr before word", m,
                         clr_last_cyc, first_xfer_cyc);
            end
            checks++;
            if (md_cyc != or_cyc + 1) begin
                errors++;
                $display("FAIL b2b%0d_done_lag: got done@%0d want %0d", m, md_cyc, or_cyc + 1);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (md_cnt != start_md + 2) begin
            errors++;
            $display("FAIL b2b_done_pulses: got %0d want %0d", md_cnt - start_md, 2);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] cap;
        bit          ok1, ok2, seen;
        int          prev;
        int          n;
        load_str("ABCDEFGH");
        build_model();
        obs_q.delete();
        prev = md_cnt;
        core_buffer_full = 1'b1;
        fork
            send_bytes(1'b1, ok1);
            begin
                seen = 1'b0;
                n    = 0;
                while (!seen && n < 100) begin
                    @(negedge clk);
                    seen = (core_in_ready === 1'b1);
                    n++;
                end
                cap = core_in;
                checks++;
                if (!seen || cap !== exp_q[0].w) begin
                    errors++;
                    $display("FAIL bp_first: got %h want %h", cap, exp_q[0].w);
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++;
                    if (core_in_ready !== 1'b1 || core_in !== cap || s_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold%0d: got rdy=%b in=%h s_ready=%b want 1/%h/0", k,
                                 core_in_ready, core_in, s_ready, cap);
                    end
                end
                @(posedge clk);
                #1;
                core_buffer_full = 1'b0;
            end
        join
        wait_done(prev, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL bp_handshake: got timeout want completion");
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d words want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word%0d: got %h/%b/%0d want %h/%b/%0d", i, obs_q[i].w,
                         obs_q[i].last, obs_q[i].bn, exp_q[i].w, exp_q[i].last, exp_q[i].bn);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2;
        int prev;
        msg_q.delete();
        msg_q.push_back(8'($urandom_range(1, 255)));
        msg_q.push_back(8'($urandom_range(1, 255)));
        obs_q.delete();
        send_bytes(1'b0, ok1);
        checks++;
        if (!ok1 || busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got busy=%b s_ready=%b want 1/1", busy, s_ready);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({s_ready, core_reset, core_in_ready, core_is_last, busy, msg_done} !== 6'b0 ||
            core_in !== 32'h0 || core_byte_num !== 2'd0) begin
            errors++;
            $display("FAIL abort_outputs: got flags=%b in=%h bn=%0d want 0/0/0",
                     {s_ready, core_reset, core_in_ready, core_is_last, busy, msg_done}, core_in,
                     core_byte_num);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_flush: got %0d words want 0", obs_q.size());
        end
        msg_q.delete();
        msg_q.push_back(8'h5A);
        build_model();
        obs_q.delete();
        clr_hi = 0;
        prev = md_cnt;
        send_bytes(1'b1, ok1);
        wait_done(prev, ok2);
        checks++;
        if (!(ok1 && ok2) || clr_hi != CLR) begin
            errors++;
            $display("FAIL abort_restart: got clr=%0d want %0d with completion", clr_hi, CLR);
        end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL abort_clean: got %0d words first %h want 1 word %h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].w : 32'h0, exp_q[0].w);
        end
    endtask

    task automatic test_random();
        bit ok1, ok2;
        int prev;
        int len;
        gap_en  = 1'b1;
        bp_rand = 1'b1;
        for (int m = 0; m < 25; m++) begin
            len = $urandom_range(1, 20);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            build_model();
            obs_q.delete();
            or_delay = $urandom_range(1, 10);
            prev = md_cnt;
            send_bytes(1'b1, ok1);
            wait_done(prev, ok2);
            checks++;
            if (!(ok1 && ok2)) begin
                errors++;
                $display("FAIL rnd%0d_handshake: got timeout want completion (len %0d)", m, len);
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_count: got %0d words want %0d", m, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_word%0d: got %h/%b/%0d want %h/%b/%0d", m, i, obs_q[i].w,
                             obs_q[i].last, obs_q[i].bn, exp_q[i].w, exp_q[i].last, exp_q[i].bn);
                end
            end
        end
        gap_en  = 1'b0;
        bp_rand = 1'b0;
        @(posedge clk);
        #1;
        core_buffer_full = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        s_data           = 8'h00;
        s_valid          = 1'b0;
        s_last           = 1'b0;
        core_buffer_full = 1'b0;
        core_out_ready   = 1'b0;
        #1;
        reset = 1'b0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
